// File: rtl/rf_write_scheduler.sv
// Register-file write-port arbiter and long-latency scoreboard: pipeline
// writeback always owns the port; long-unit results fill the idle cycles.
module rf_write_scheduler #(
    parameter int LU_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rs,
    input  logic [4:0]  iss_rt,
    input  logic        iss_use_rs,
    input  logic        iss_use_rt,
    input  logic [4:0]  iss_rd,
    input  logic        iss_wr,
    input  logic        iss_long,
    output logic        stall,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [3:0]  lu_busy_cnt
);
    localparam logic [3:0] DEPTH_MAX = 4'(LU_DEPTH);
    localparam logic [3:0] SC_MAX    = 4'(STARVE_LIMIT);

    logic [31:0] busy;
    logic [31:0] busy_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [3:0]  sc;
    logic        wb_live;
    logic        lu_hs;
    logic        starving;
    logic        hazard;
    logic        issue;
    logic        lu_inc;

    // stall and lu_ready are built only from state and inputs; neither feeds the other
    always_comb begin
        wb_live  = wb_valid && (wb_rd != 5'd0);
        lu_ready = lu_valid && !wb_live;
        lu_hs    = lu_ready;
        starving = (sc == SC_MAX);
        hazard   = (iss_use_rs && busy[iss_rs])
                || (iss_use_rt && busy[iss_rt])
                || (iss_wr && busy[iss_rd])
                || (iss_long && (cnt == DEPTH_MAX))
                || starving;
        stall    = iss_valid && hazard;
        issue    = iss_valid && !hazard;
        lu_inc   = issue && iss_long;
    end

    always_comb begin
        busy_next = busy;
        if (lu_hs)
            busy_next[lu_rd] = 1'b0;
        if (lu_inc && iss_wr)
            busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = cnt;
        case ({lu_inc, lu_hs})
            2'b10:   cnt_next = cnt + 4'd1;
            2'b01:   cnt_next = cnt - 4'd1;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= '0;
            cnt   <= '0;
            sc    <= '0;
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            busy <= busy_next;
            cnt  <= cnt_next;
            if (lu_valid && !lu_ready)
                sc <= starving ? sc : sc + 4'd1;
            else
                sc <= '0;
            if (wb_live) begin
                rf_we <= 1'b1;
                rf_wa <= wb_rd;
                rf_wd <= wb_data;
            end else if (lu_hs && (lu_rd != 5'd0)) begin
                rf_we <= 1'b1;
                rf_wa <= lu_rd;
                rf_wd <= lu_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    assign lu_busy_cnt = cnt;

    // A result with no outstanding request, or for a register not marked busy, is a long-unit bug
    a_lu_cnt:  assert property (@(posedge clk) disable iff (reset) lu_valid |-> (cnt != 4'd0));
    a_lu_busy: assert property (@(posedge clk) disable iff (reset)
                                (lu_valid && (lu_rd != 5'd0)) |-> busy[lu_rd]);

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Write-port scheduler and scoreboard for the pipelined core's 32×32 register file. It shares the file's single write port between in-order pipeline writeback and out-of-band results from the long-latency unit (mul/div). It tracks destination registers with pending long-latency results and generates the issue stall for RAW/WAW hazards on them. It sits between the decode/issue stage, the writeback stage, the long-latency unit and the register file write inputs (write enable, write address, write data).

## Interface
Parameters:
- LU_DEPTH, 4: maximum long-latency results outstanding (1..15).
- STARVE_LIMIT, 8: consecutive refused cycles before the long-unit result is declared starving (1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- iss_valid  in  1  decode presents an instruction for issue.
- iss_rs, iss_rt  in  5 each  source register numbers.
- iss_use_rs, iss_use_rt  in  1 each  instruction reads that source.
- iss_rd  in  5  destination register number.
- iss_wr  in  1  instruction writes iss_rd.
- iss_long  in  1  instruction is dispatched to the long-latency unit.
- stall  out  1  issue blocked this cycle (combinational).
- wb_valid  in  1  pipeline writeback valid; cannot be back-pressured.
- wb_rd  in  5  pipeline writeback register.
- wb_data  in  32  pipeline writeback data.
- lu_valid  in  1  long-unit result valid.
- lu_rd  in  5  long-unit result register.
- lu_data  in  32  long-unit result data.
- lu_ready  out  1  long-unit result accepted this cycle (combinational).
- rf_we  out  1  register file write enable (registered).
- rf_wa  out  5  register file write address (registered).
- rf_wd  out  32  register file write data (registered).
- lu_busy_cnt  out  4  number of outstanding long results (registered).

## Operation
- State:
  - busy[31:1] scoreboard bits; busy[0] is constant 0.
  - outstanding counter `cnt`, 0..LU_DEPTH.
  - starvation counter `sc`, 0..STARVE_LIMIT, saturating.
  - output registers rf_we/rf_wa/rf_wd.
- Issue acceptance: `issue = iss_valid & ~stall`.
- `starving = (sc == STARVE_LIMIT)`.
- stall = iss_valid & (any of the following):
  - iss_use_rs & busy[iss_rs]
  - iss_use_rt & busy[iss_rt]
  - iss_wr & busy[iss_rd] (WAW)
  - iss_long & (cnt == LU_DEPTH)
  - starving
- Scoreboard set: on issue & iss_long & iss_wr & (iss_rd != 0), set busy[iss_rd].
- Counter increment: cnt increments on issue & iss_long, whether or not the instruction writes.
- wb_live = wb_valid & (wb_rd != 0). Pipeline writeback always wins the port.
- lu_ready = lu_valid & ~wb_live. A long result whose lu_rd = 0 is accepted but writes nothing.
- Long-unit handshake (lu_valid & lu_ready):
  - clear busy[lu_rd];
  - decrement cnt.
- Same-cycle increment and decrement leave cnt unchanged.
- Port register loads each edge:
  - wb_live: rf_we=1, rf_wa=wb_rd, rf_wd=wb_data.
  - else lu handshake with lu_rd≠0: rf_we=1, rf_wa=lu_rd, rf_wd=lu_data.
  - else rf_we=0; rf_wa/rf_wd hold.
- Starvation counter:
  - sc increments (saturating) each cycle lu_valid & ~lu_ready;
  - sc clears on handshake or when lu_valid=0.
  - Once starving, issue stops, so pipeline writebacks drain and the long result is granted.
- A write to r0 never asserts rf_we.
- Illegal stimulus:
  - lu_valid when cnt=0;
  - lu_rd not busy (other than 0).
  - Sim-only assertion fires; RTL behaviour is undefined.

## Timing
- Reset (async, immediate): busy=0, cnt=0, sc=0, rf_we=0, rf_wa=0, rf_wd=0, lu_busy_cnt=0.
- Combinational outputs during reset: stall and lu_ready follow their equations on reset-state values.
- Write latency: a winner at edge N drives rf_we for cycle N→N+1. The register file commits at the falling edge inside that cycle, so a same-cycle combinational read sees the new value.
- Hazard release:
  - busy clears at the handshake edge, so stall on that register drops in the following cycle;
  - the data is visible to the register file read in that same cycle (half-cycle write-before-read).
- stall and lu_ready depend only on registered state and current inputs, with no path from stall to lu_ready.
- Issue in the same cycle as the handshake for the same register sees the old busy=1 and stalls one extra cycle (conservative).
- Reset mid-operation discards all pending scoreboard state. The long unit must be reset by the same signal.

## Test plan
- Reset with busy state set → immediately busy=0, cnt=0, rf_we=0. First edge after deassert with no inputs → rf_we stays 0.
- Issue long op rd=5; next cycle issue with rs=5 → stall=1. lu_valid, rd=5, data 0x1234ABCD, wb idle → lu_ready=1; next cycle rf_we=1, rf_wa=5, rf_wd=0x1234ABCD, and stall drops.
- Same cycle: wb_valid rd=3 data 0x11 and lu_valid rd=7 → rf_wa=3, lu_ready=0. Next cycle wb idle → rf_wa=7 written.
- LU_DEPTH=4: four long issues → cnt=4; fifth long issue → stall=1. Non-long issue → no stall. One handshake → stall releases the next cycle.
- wb_valid held with rd≠0 and lu_valid waiting 8 cycles → sc=8, stall=1 for any iss_valid. When wb_valid drops, handshake occurs, sc returns to 0 and stall clears.
- Issue long with rd=0, then lu result rd=0 → busy unchanged, rf_we=0, cnt returns to 0. Issue with rs=0 never stalls.
